montprod_opmem: RTL and testbench

- Operand/result memory and sequencer that sits on the far side of the montprod operand interface.
- Holds the A, B and M operand words and serves them combinationally on the opa/opb/opm read ports.
- Captures result words written by montprod, and pulses calculate then waits for ready.
- Exposes a host word interface (cs/we/address) so the top-level API can load operands, start the product and read the result.

---
 rtl/montprod_opmem.sv | 212 +++++++++++++++++++++
 tb/tb_montprod_opmem.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/montprod_opmem.sv
// montprod_opmem: operand/result memory and start/ready sequencer for montprod.
// Ports: clk, reset_n (async low); host cs/we/address/write_data/read_data
//   (address MSB: 0=memory banks A/B/M/R, 1=registers CTRL/STATUS/LENGTH/CYCLES);
//   montprod side mp_calculate/mp_ready/mp_length, opa/opb/opm combinational
//   read ports, result_addr/result_data/result_we write port.
// Optional: define MONTPROD_OPMEM_CYCLES_EN for the busy-cycle counter (reg 3).
module montprod_opmem #(
   parameter int OPW = 32,
   parameter int AW  = 8
) (
   input  logic           clk,
   input  logic           reset_n,
   input  logic           cs,
   input  logic           we,
   input  logic [AW+2:0]  address,
   input  logic [OPW-1:0] write_data,
   output logic [OPW-1:0] read_data,
   output logic           mp_calculate,
   input  logic           mp_ready,
   output logic [7:0]     mp_length,
   input  logic [AW-1:0]  opa_addr,
   output logic [OPW-1:0] opa_data,
   input  logic [AW-1:0]  opb_addr,
   output logic [OPW-1:0] opb_data,
   input  logic [AW-1:0]  opm_addr,
   output logic [OPW-1:0] opm_data,
   input  logic [AW-1:0]  result_addr,
   input  logic [OPW-1:0] result_data,
   input  logic           result_we
);

   localparam int DEPTH = 2 ** AW;

   localparam logic [1:0] BANK_A = 2'd0;
   localparam logic [1:0] BANK_B = 2'd1;
   localparam logic [1:0] BANK_M = 2'd2;

   localparam logic [1:0] REG_CTRL   = 2'd0;
   localparam logic [1:0] REG_STATUS = 2'd1;
   localparam logic [1:0] REG_LENGTH = 2'd2;
   localparam logic [1:0] REG_CYCLES = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE,
      S_PULSE,
      S_ARMED,
      S_WAIT
   } state_t;

   logic [OPW-1:0] mem_a [DEPTH];
   logic [OPW-1:0] mem_b [DEPTH];
   logic [OPW-1:0] mem_m [DEPTH];
   logic [OPW-1:0] mem_r [DEPTH];

   state_t         state_q, state_d;
   logic [7:0]     length_q, length_d;
   logic           done_q, done_d;
   logic           err_q, err_d;
   logic [OPW-1:0] rdata_q, rdata_d;

   logic           ready;
   logic           host_wr;
   logic           host_rd;
   logic           is_reg;
   logic [1:0]     bank;
   logic [AW-1:0]  word;
   logic [1:0]     reg_sel;
   logic           mem_wr;
   logic           opnd_wr;
   logic           len_wr;
   logic           start_req;
   logic           wr_a, wr_b, wr_m, wr_r;
   logic [OPW-1:0] status;
   logic [OPW-1:0] cycles_rd;

   assign host_wr = cs & we;
   assign host_rd = cs & ~we;
   assign is_reg  = address[AW+2];
   assign bank    = address[AW+1:AW];
   assign word    = address[AW-1:0];
   assign reg_sel = address[1:0];

   assign ready = (state_q == S_IDLE);

   // Bank R is never host-writable, so it is not an operand write.
   assign mem_wr    = host_wr & ~is_reg;
   assign opnd_wr   = mem_wr & (bank != 2'd3);
   assign len_wr    = host_wr & is_reg & (reg_sel == REG_LENGTH);
   assign start_req = host_wr & is_reg & (reg_sel == REG_CTRL)
                      & write_data[0];

   assign wr_a = ready & opnd_wr & (bank == BANK_A);
   assign wr_b = ready & opnd_wr & (bank == BANK_B);
   assign wr_m = ready & opnd_wr & (bank == BANK_M);
   assign wr_r = ~ready & result_we;

   assign status = {{(OPW-3){1'b0}}, err_q, done_q, ready};

   assign opa_data = mem_a[opa_addr];
   assign opb_data = mem_b[opb_addr];
   assign opm_data = mem_m[opm_addr];

   assign read_data    = rdata_q;
   assign mp_calculate = (state_q == S_PULSE);
   assign mp_length    = length_q;

   // Arrays are deliberately unreset so contents survive reset_n.
   always_ff @(posedge clk) begin
      if (wr_a) mem_a[word] <= write_data;
      if (wr_b) mem_b[word] <= write_data;
      if (wr_m) mem_m[word] <= write_data;
      if (wr_r) mem_r[result_addr] <= result_data;
   end

   always_comb begin
      state_d  = state_q;
      length_d = length_q;
      done_d   = done_q;
      err_d    = err_q;

      unique case (state_q)
         S_IDLE: begin
            if (len_wr) length_d = write_data[7:0];
            if (start_req) begin
               if (length_q != 8'd0) begin
                  done_d  = 1'b0;
                  err_d   = 1'b0;
                  state_d = S_PULSE;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         S_PULSE: state_d = S_ARMED;
         // montprod may still show ready the cycle after calculate.
         S_ARMED: if (!mp_ready) state_d = S_WAIT;
         S_WAIT: begin
            if (mp_ready) begin
               done_d  = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (!ready && (opnd_wr || len_wr)) err_d = 1'b1;
   end

   // Registered host read; a same-edge R write is seen on the next read.
   always_comb begin
      rdata_d = rdata_q;
      if (host_rd) begin
         if (is_reg) begin
            unique case (reg_sel)
               REG_CTRL:   rdata_d = '0;
               REG_STATUS: rdata_d = status;
               REG_LENGTH: rdata_d = {{(OPW-8){1'b0}}, length_q};
               REG_CYCLES: rdata_d = cycles_rd;
               default:    rdata_d = '0;
            endcase
         end else begin
            unique case (bank)
               2'd0:    rdata_d = mem_a[word];
               2'd1:    rdata_d = mem_b[word];
               2'd2:    rdata_d = mem_m[word];
               2'd3:    rdata_d = mem_r[word];
               default: rdata_d = '0;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         length_q <= 8'd0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         rdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         length_q <= length_d;
         done_q   <= done_d;
         err_q    <= err_d;
         rdata_q  <= rdata_d;
      end
   end

`ifdef MONTPROD_OPMEM_CYCLES_EN
   logic [31:0] cycles_q, cycles_d;

   // Counts every cycle spent outside IDLE, restarting at each launch.
   always_comb begin
      cycles_d = cycles_q;
      if (state_q == S_IDLE) begin
         if (state_d == S_PULSE) cycles_d = 32'd0;
      end else if (cycles_q != 32'hFFFF_FFFF) begin
         cycles_d = cycles_q + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) cycles_q <= 32'd0;
      else          cycles_q <= cycles_d;
   end

   assign cycles_rd = cycles_q;
`else
   assign cycles_rd = '0;
`endif

endmodule

// File: tb/tb_montprod_opmem.sv
// Self-checking bench for montprod_opmem against a behavioural model
// of the banks and the start/done/err register rules.
module tb_montprod_opmem;

   localparam int AW = 8;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          cs = 1'b0;
   logic          we = 1'b0;
   logic [AW+2:0] address = '0;
   logic [31:0]   write_data = '0;
   logic [31:0]   read_data;
   logic          mp_calculate;
   logic          mp_ready = 1'b1;
   logic [7:0]    mp_length;
   logic [AW-1:0] opa_addr = '0;
   logic [31:0]   opa_data;
   logic [AW-1:0] opb_addr = '0;
   logic [31:0]   opb_data;
   logic [AW-1:0] opm_addr = '0;
   logic [31:0]   opm_data;
   logic [AW-1:0] result_addr = '0;
   logic [31:0]   result_data = '0;
   logic          result_we = 1'b0;

   int n_tests = 0;
   int n_fail  = 0;

   // Model state
   logic [31:0] mdl [4][256];
   logic [7:0]  len_m;
   int          wb_q[$];
   int          ww_q[$];

   montprod_opmem #(.OPW(32), .AW(AW)) dut (
      .clk(clk), .reset_n(reset_n), .cs(cs), .we(we),
      .address(address), .write_data(write_data),
      .read_data(read_data), .mp_calculate(mp_calculate),
      .mp_ready(mp_ready), .mp_length(mp_length),
      .opa_addr(opa_addr), .opa_data(opa_data),
      .opb_addr(opb_addr), .opb_data(opb_data),
      .opm_addr(opm_addr), .opm_data(opm_data),
      .result_addr(result_addr), .result_data(result_data),
      .result_we(result_we)
   );

   always #5 clk = ~clk;

   function automatic logic [AW+2:0] maddr(int b, int w);
      logic [1:0] bb;
      logic [7:0] ww;
      bb = 2'(b);
      ww = 8'(w);
      return {1'b0, bb, ww};
   endfunction

   function automatic logic [AW+2:0] raddr(int r);
      logic [1:0] rr;
      rr = 2'(r);
      return {1'b1, 8'd0, rr};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic host_write(input logic [AW+2:0] a, input logic [31:0] d);
      cs = 1'b1; we = 1'b1; address = a; write_data = d;
      tick();
      cs = 1'b0; we = 1'b0;
   endtask

   task automatic host_read(input logic [AW+2:0] a, output logic [31:0] d);
      cs = 1'b1; we = 1'b0; address = a;
      tick();
      cs = 1'b0;
      d = read_data;
   endtask

   // Polls STATUS until ready, bounded; ok=0 on timeout.
   task automatic wait_idle(output bit ok, output logic [31:0] st);
      ok = 1'b0;
      st = '0;
      for (int i = 0; i < 40; i++) begin
         host_read(raddr(1), st);
         if (st[0]) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      logic [31:0] d;
      #3;
      n_tests++;
      if (mp_calculate !== 1'b0 || read_data !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_outputs calc=%b rd=%h want 0/0",
                  mp_calculate, read_data);
      end
      tick();
      reset_n = 1'b1;
      len_m = 8'd0;
      host_read(raddr(1), d);
      n_tests++;
      if (d !== 32'h1) begin
         n_fail++;
         $display("FAIL reset_status got %h want 1", d);
      end
      host_read(raddr(2), d);
      n_tests++;
      if (d !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_length got %h want 0", d);
      end
      host_read(raddr(3), d);
      n_tests++;
      if (d !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_cycles got %h want 0", d);
      end
      n_tests++;
      if (mp_calculate !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_calc got %b want 0", mp_calculate);
      end
   endtask

   task automatic test_mem();
      logic [31:0] d;
      host_write(maddr(0, 5), 32'hDEADBEEF);
      mdl[0][5] = 32'hDEADBEEF;
      opa_addr = 8'd5;
      #1;
      n_tests++;
      if (opa_data !== 32'hDEADBEEF) begin
         n_fail++;
         $display("FAIL opa_comb got %h want deadbeef", opa_data);
      end
      host_read(maddr(0, 5), d);
      n_tests++;
      if (d !== 32'hDEADBEEF) begin
         n_fail++;
         $display("FAIL host_read_a5 got %h want deadbeef", d);
      end
   endtask

   task automatic test_random();
      logic [31:0] d;
      int b, w, k;
      for (int i = 0; i < 40; i++) begin
         b = $urandom_range(0, 2);
         w = $urandom_range(0, 255);
         d = $urandom;
         host_write(maddr(b, w), d);
         mdl[b][w] = d;
         wb_q.push_back(b);
         ww_q.push_back(w);
      end
      for (int i = 0; i < 30; i++) begin
         k = $urandom_range(0, wb_q.size() - 1);
         b = wb_q[k];
         w = ww_q[k];
         host_read(maddr(b, w), d);
         n_tests++;
         if (d !== mdl[b][w]) begin
            n_fail++;
            $display("FAIL rand_read b%0d w%0d got %h want %h",
                     b, w, d, mdl[b][w]);
         end
         opa_addr = 8'(w);
         opb_addr = 8'(w);
         opm_addr = 8'(w);
         #1;
         d = (b == 0) ? opa_data : (b == 1) ? opb_data : opm_data;
         n_tests++;
         if (d !== mdl[b][w]) begin
            n_fail++;
            $display("FAIL rand_opport b%0d w%0d got %h want %h",
                     b, w, d, mdl[b][w]);
         end
      end
   endtask

   task automatic test_product();
      logic [31:0] d;
      int pulses;
      bit ok;
      host_write(raddr(2), 32'd4);
      len_m = 8'd4;
      host_write(raddr(0), 32'd1);
      pulses = 0;
      if (mp_calculate) pulses++;
      mp_ready = 1'b0;
      tick();
      if (mp_calculate) pulses++;
      for (int i = 0; i < 4; i++) begin
         result_we = 1'b1;
         result_addr = 8'(i);
         result_data = 32'(i + 1);
         mdl[3][i] = 32'(i + 1);
         tick();
         if (mp_calculate) pulses++;
      end
      result_we = 1'b0;
      for (int i = 0; i < 15; i++) begin
         tick();
         if (mp_calculate) pulses++;
      end
      n_tests++;
      if (mp_length !== 8'd4) begin
         n_fail++;
         $display("FAIL prod_length got %0d want 4", mp_length);
      end
      mp_ready = 1'b1;
      wait_idle(ok, d);
      n_tests++;
      if (!ok || pulses != 1) begin
         n_fail++;
         $display("FAIL prod_pulse ok=%0d pulses=%0d want 1/1", ok, pulses);
      end
      n_tests++;
      if (d !== 32'h3) begin
         n_fail++;
         $display("FAIL prod_status got %h want 3", d);
      end
      host_write(maddr(3, 0), 32'hFFFF0000);
      for (int i = 0; i < 4; i++) begin
         host_read(maddr(3, i), d);
         n_tests++;
         if (d !== mdl[3][i]) begin
            n_fail++;
            $display("FAIL prod_r%0d got %h want %h", i, d, mdl[3][i]);
         end
      end
      host_read(raddr(3), d);
      n_tests++;
`ifdef MONTPROD_OPMEM_CYCLES_EN
      if (d < 32'd20 || d > 32'd23) begin
         n_fail++;
         $display("FAIL prod_cycles got %0d want 20..23", d);
      end
`else
      if (d !== 32'd0) begin
         n_fail++;
         $display("FAIL prod_cycles got %0d want 0", d);
      end
`endif
   endtask

   task automatic test_ready_lag();
      logic [31:0] d;
      bit ok;
      host_write(raddr(0), 32'd1);
      tick();
      tick();
      host_read(raddr(1), d);
      n_tests++;
      if (d !== 32'h0) begin
         n_fail++;
         $display("FAIL lag_busy1 got %h want 0", d);
      end
      host_read(raddr(1), d);
      n_tests++;
      if (d !== 32'h0) begin
         n_fail++;
         $display("FAIL lag_busy2 got %h want 0", d);
      end
      mp_ready = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      mp_ready = 1'b1;
      wait_idle(ok, d);
      n_tests++;
      if (!ok || d !== 32'h3) begin
         n_fail++;
         $display("FAIL lag_done ok=%0d got %h want 3", ok, d);
      end
   endtask

   task automatic test_busy_write();
      logic [31:0] d;
      logic [31:0] old;
      bit ok;
      old = $urandom;
      host_write(maddr(0, 0), old);
      mdl[0][0] = old;
      host_write(raddr(0), 32'd1);
      mp_ready = 1'b0;
      tick();
      host_write(maddr(0, 0), ~old);
      host_write(raddr(2), 32'd9);
      n_tests++;
      if (mp_length !== len_m) begin
         n_fail++;
         $display("FAIL busy_mplen got %0d want %0d", mp_length, len_m);
      end
      mp_ready = 1'b1;
      wait_idle(ok, d);
      host_read(raddr(1), d);
      n_tests++;
      if (!ok || d !== 32'h7) begin
         n_fail++;
         $display("FAIL busy_err ok=%0d got %h want 7", ok, d);
      end
      host_read(maddr(0, 0), d);
      n_tests++;
      if (d !== old) begin
         n_fail++;
         $display("FAIL busy_a0 got %h want %h", d, old);
      end
      host_read(raddr(2), d);
      n_tests++;
      if (d !== 32'(len_m)) begin
         n_fail++;
         $display("FAIL busy_len got %h want %h", d, len_m);
      end
      host_write(raddr(0), 32'd1);
      host_read(raddr(1), d);
      n_tests++;
      if (d !== 32'h0) begin
         n_fail++;
         $display("FAIL busy_errclr got %h want 0", d);
      end
      mp_ready = 1'b0;
      tick();
      mp_ready = 1'b1;
      wait_idle(ok, d);
      n_tests++;
      if (!ok || d !== 32'h3) begin
         n_fail++;
         $display("FAIL busy_redo ok=%0d got %h want 3", ok, d);
      end
   endtask

   task automatic test_reset_in_wait();
      logic [31:0] d;
      host_write(raddr(0), 32'd1);
      mp_ready = 1'b0;
      tick();
      tick();
      #2;
      reset_n = 1'b0;
      #1;
      n_tests++;
      if (mp_calculate !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_calc got %b want 0", mp_calculate);
      end
      tick();
      reset_n = 1'b1;
      mp_ready = 1'b1;
      len_m = 8'd0;
      host_read(raddr(1), d);
      n_tests++;
      if (d !== 32'h1) begin
         n_fail++;
         $display("FAIL rst_status got %h want 1", d);
      end
      result_we = 1'b1;
      result_addr = 8'd0;
      result_data = 32'h0BAD0BAD;
      tick();
      result_we = 1'b0;
      host_read(maddr(3, 0), d);
      n_tests++;
      if (d !== mdl[3][0]) begin
         n_fail++;
         $display("FAIL rst_idle_rwe got %h want %h", d, mdl[3][0]);
      end
      host_read(maddr(0, 5), d);
      n_tests++;
      if (d !== mdl[0][5]) begin
         n_fail++;
         $display("FAIL rst_retain got %h want %h", d, mdl[0][5]);
      end
   endtask

   task automatic test_len0();
      logic [31:0] d;
      int pulses;
      pulses = 0;
      host_write(raddr(2), 32'd0);
      host_write(raddr(0), 32'd1);
      if (mp_calculate) pulses++;
      host_read(raddr(1), d);
      if (mp_calculate) pulses++;
      n_tests++;
      if (d !== 32'h3 || pulses != 0) begin
         n_fail++;
         $display("FAIL len0 status=%h pulses=%0d want 3/0", d, pulses);
      end
   endtask

   initial begin
      test_reset();
      test_mem();
      test_random();
      test_product();
      test_ready_lag();
      test_busy_write();
      test_reset_in_wait();
      test_len0();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
